// File: rtl/sm83_irq_pkg.sv
// ---------------------------------------------------------------------------
// sm83_irq_pkg
// Shared types and constants for the sm83 interrupt controller.
//   irq_t            : interrupt vector type (IF / IE / irq / iack width)
//   IRQ_*            : bit index of each implemented interrupt source
//   IF_ADR_DEF       : default bus address of the interrupt flag register
//   IE_ADR_DEF       : default bus address of the interrupt enable register
// ---------------------------------------------------------------------------
package sm83_irq_pkg;

  localparam int NUM_IRQS_DEF = 8;
  localparam int NUM_SRC_DEF  = 5;

  typedef logic [NUM_IRQS_DEF-1:0] irq_t;

  // Source bit positions; lower index means higher priority in the core.
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] IF_ADR_DEF = 16'hff0f;
  localparam logic [15:0] IE_ADR_DEF = 16'hffff;

endpackage

// File: rtl/sm83_irq_edge.sv
// ---------------------------------------------------------------------------
// sm83_irq_edge
// Rising-edge detector for the peripheral request lines.
//   clk     in  1  clock
//   reset   in  1  asynchronous, active-high
//   i_req   in  W  request levels
//   o_set   out W  one-cycle pulse where i_req is 1 and was 0 last cycle
// The delayed copy clears to 0 in reset, so a request that is already high
// when reset releases produces a pulse at the first clock edge.
// ---------------------------------------------------------------------------
module sm83_irq_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_req,
  output logic [W-1:0] o_set
);

  logic [W-1:0] r_req_q;

  // NOTE: only the flops that define visible state get a reset term; this
  // one must, because its reset value decides the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, regardless
      // of statement order or which block reads the result.
      r_req_q <= i_req;
    end
  end

  assign o_set = i_req & ~r_req_q;

endmodule

// File: rtl/sm83_irq_ctrl.sv
// ---------------------------------------------------------------------------
// sm83_irq_ctrl
// Interrupt controller in front of the sm83 core. Holds IF and IE, latches
// rising edges of peripheral requests into IF, drives irq = IF & IE to the
// core, clears IF bits on iack, and exposes both registers on the core bus.
//   clk      in   1         clock, all state updates on posedge
//   reset    in   1         asynchronous, active-high
//   adr      in   16        bus address
//   din      in   8         write data
//   dout     out  8         read data, 0 whenever dout_oe is 0
//   dout_oe  out  1         read of IF or IE in progress
//   rd       in   1         read strobe (level)
//   wr       in   1         write strobe, commits at the posedge
//   req      in   NUM_SRC   peripheral request levels
//   irq      out  NUM_IRQS  pending and enabled interrupts
//   iack     in   NUM_IRQS  one-hot acknowledge from the core
//   wake     out  1         any irq bit set (HALT/STOP release)
// ---------------------------------------------------------------------------
module sm83_irq_ctrl
  import sm83_irq_pkg::*;
#(
  parameter int          NUM_IRQS = NUM_IRQS_DEF,
  parameter int          NUM_SRC  = NUM_SRC_DEF,
  parameter logic [15:0] IF_ADR   = IF_ADR_DEF,
  parameter logic [15:0] IE_ADR   = IE_ADR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         adr,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                dout_oe,
  input  logic                rd,
  input  logic                wr,
  input  logic [NUM_SRC-1:0]  req,
  output logic [NUM_IRQS-1:0] irq,
  input  logic [NUM_IRQS-1:0] iack,
  output logic                wake
);

  logic [NUM_SRC-1:0]  r_if;
  logic [NUM_IRQS-1:0] r_ie;

  logic                w_sel_if;
  logic                w_sel_ie;
  logic                w_wr_if;
  logic                w_wr_ie;
  logic [NUM_SRC-1:0]  w_set;
  logic [NUM_SRC-1:0]  w_if_base;
  logic [NUM_IRQS-1:0] w_if_rd;
  logic [NUM_IRQS-1:0] w_irq;
  logic                w_unused_iack;

  sm83_irq_edge #(
    .W (NUM_SRC)
  ) u_edge (
    .clk   (clk),
    .reset (reset),
    .i_req (req),
    .o_set (w_set)
  );

  assign w_sel_if = (adr == IF_ADR);
  assign w_sel_ie = (adr == IE_ADR);
  assign w_wr_if  = wr && w_sel_if;
  assign w_wr_ie  = wr && w_sel_ie;

  // Write data or held value, then iack clears, then new edges set: a
  // request arriving in the same cycle as an ack or a write is never lost.
  assign w_if_base = w_wr_if ? din[NUM_SRC-1:0] : r_if;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if <= '0;
      r_ie <= '0;
    end else begin
      r_if <= (w_if_base & ~iack[NUM_SRC-1:0]) | w_set;
      if (w_wr_ie) begin
        r_ie <= NUM_IRQS'(din);
      end
    end
  end

  // Unimplemented IF bits read as 1; only the implemented ones reach irq.
  // NOTE: every always_comb output gets a full default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_if_rd              = '1;
    w_if_rd[NUM_SRC-1:0] = r_if;
    w_irq                = '0;
    w_irq[NUM_SRC-1:0]   = r_if & r_ie[NUM_SRC-1:0];
  end

  // Read mux shows pre-edge register contents, so a read and write to the
  // same address in one cycle returns the old value.
  always_comb begin
    dout_oe = rd && (w_sel_if || w_sel_ie);
    dout    = 8'h00;
    if (rd && w_sel_if) begin
      dout = 8'(w_if_rd);
    end else if (rd && w_sel_ie) begin
      dout = 8'(r_ie);
    end
  end

  assign irq  = w_irq;
  assign wake = |w_irq;

  // Acknowledge bits above the implemented sources have nothing to clear.
  assign w_unused_iack = ^iack;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sm83_irq_ctrl
// Self-checking bench for sm83_irq_ctrl: a directed vector table, hand
// sequences for reset with a held request, then randomized traffic compared
// against a bit-level behavioural model of IF / IE.
// ---------------------------------------------------------------------------
module tb_sm83_irq_ctrl;
  import sm83_irq_pkg::*;

  localparam logic [15:0] IFA = IF_ADR_DEF;
  localparam logic [15:0] IEA = IE_ADR_DEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        rd;
  logic        wr;
  logic [4:0]  req;
  irq_t        irq;
  irq_t        iack;
  logic        wake;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sm83_irq_ctrl #(
    .NUM_IRQS (8),
    .NUM_SRC  (5),
    .IF_ADR   (IF_ADR_DEF),
    .IE_ADR   (IE_ADR_DEF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .adr     (adr),
    .din     (din),
    .dout    (dout),
    .dout_oe (dout_oe),
    .rd      (rd),
    .wr      (wr),
    .req     (req),
    .irq     (irq),
    .iack    (iack),
    .wake    (wake)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic r,
                       input logic w, input logic [4:0] q, input logic [7:0] k);
    adr  = a;
    din  = d;
    rd   = r;
    wr   = w;
    req  = q;
    iack = k;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] e_irq,
                            input logic e_oe, input logic [7:0] e_dout);
    check({tag, ".irq"},     {8'h00, irq},     {8'h00, e_irq});
    check({tag, ".wake"},    {15'h0, wake},    {15'h0, |e_irq});
    check({tag, ".dout_oe"}, {15'h0, dout_oe}, {15'h0, e_oe});
    check({tag, ".dout"},    {8'h00, dout},    {8'h00, e_dout});
  endtask

  // Advance one clock; inputs change 1 ns after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] adr;
    logic [7:0]  din;
    logic        rd;
    logic        wr;
    logic [4:0]  req;
    logic [7:0]  iack;
    logic [7:0]  e_irq;
    logic        e_oe;
    logic [7:0]  e_dout;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  // ---------------- behavioural model ----------------
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic [4:0] m_req_prev;

  task automatic model_reset();
    m_if       = '0;
    m_ie       = '0;
    m_req_prev = '0;
  endtask

  // One clock edge of the register rules, bit by bit in priority order.
  task automatic model_step();
    for (int i = 0; i < 5; i++) begin
      if (req[i] && !m_req_prev[i])      m_if[i] = 1'b1;
      else if (iack[i])                  m_if[i] = 1'b0;
      else if (wr && adr == IFA)         m_if[i] = din[i];
    end
    if (wr && adr == IEA) m_ie = din;
    m_req_prev = req;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_irq;
    logic       e_oe;
    logic [7:0] e_dout;
    e_irq  = {3'b000, m_if & m_ie[4:0]};
    e_oe   = rd && (adr == IFA || adr == IEA);
    e_dout = !e_oe ? 8'h00 : (adr == IFA) ? {3'b111, m_if} : m_ie;
    check_outs(tag, e_irq, e_oe, e_dout);
  endtask

  initial begin
    //      adr      din    rd  wr  req    iack   irq    oe  dout
    vecs[0]  = '{IEA,      8'h01, 0, 1, 5'h00, 8'h00, 8'h00, 0, 8'h00};
    vecs[1]  = '{IEA,      8'h00, 0, 0, 5'h01, 8'h00, 8'h00, 0, 8'h00};
    vecs[2]  = '{IFA,      8'h00, 1, 0, 5'h00, 8'h00, 8'h01, 1, 8'he1};
    vecs[3]  = '{IFA,      8'h00, 1, 0, 5'h00, 8'h01, 8'h01, 1, 8'he1};
    vecs[4]  = '{IFA,      8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 1, 8'he0};
    vecs[5]  = '{IEA,      8'h00, 0, 1, 5'h00, 8'h00, 8'h00, 0, 8'h00};
    vecs[6]  = '{IFA,      8'h00, 0, 0, 5'h04, 8'h00, 8'h00, 0, 8'h00};
    vecs[7]  = '{IFA,      8'h00, 1, 0, 5'h04, 8'h00, 8'h00, 1, 8'he4};
    vecs[8]  = '{IEA,      8'h04, 0, 1, 5'h04, 8'h00, 8'h00, 0, 8'h00};
    vecs[9]  = '{IEA,      8'h00, 1, 0, 5'h04, 8'h00, 8'h04, 1, 8'h04};
    vecs[10] = '{IEA,      8'h06, 0, 1, 5'h04, 8'h00, 8'h04, 0, 8'h00};
    vecs[11] = '{IFA,      8'h00, 0, 0, 5'h06, 8'h00, 8'h04, 0, 8'h00};
    vecs[12] = '{IFA,      8'h00, 1, 0, 5'h04, 8'h00, 8'h06, 1, 8'he6};
    vecs[13] = '{IFA,      8'h00, 0, 0, 5'h06, 8'h02, 8'h06, 0, 8'h00};
    vecs[14] = '{IFA,      8'h00, 1, 0, 5'h06, 8'h00, 8'h06, 1, 8'he6};
    vecs[15] = '{IFA,      8'h00, 0, 1, 5'h0e, 8'h00, 8'h06, 0, 8'h00};
    vecs[16] = '{IFA,      8'h00, 1, 0, 5'h0e, 8'h00, 8'h00, 1, 8'he8};
    vecs[17] = '{IFA,      8'hff, 0, 1, 5'h0e, 8'h00, 8'h00, 0, 8'h00};
    vecs[18] = '{IFA,      8'h00, 1, 0, 5'h0e, 8'h00, 8'h06, 1, 8'hff};
    vecs[19] = '{IEA,      8'hff, 1, 1, 5'h0e, 8'h00, 8'h06, 1, 8'h06};
    vecs[20] = '{IEA,      8'h00, 1, 0, 5'h0e, 8'h00, 8'h1f, 1, 8'hff};
    vecs[21] = '{16'hff10, 8'h00, 1, 0, 5'h0e, 8'h00, 8'h1f, 0, 8'h00};
    vecs[22] = '{16'hff10, 8'h00, 0, 1, 5'h0e, 8'h00, 8'h1f, 0, 8'h00};
    vecs[23] = '{IFA,      8'h00, 1, 0, 5'h0e, 8'h00, 8'h1f, 1, 8'hff};

    // ---- reset state ----
    reset = 1'b1;
    drive(IFA, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    #2;
    check_outs("reset", 8'h00, 1'b0, 8'h00);
    next_cycle();
    next_cycle();
    rd = 1'b1;
    #1;
    check_outs("reset_rd", 8'h00, 1'b1, 8'he0);
    next_cycle();
    reset = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].adr, vecs[i].din, vecs[i].rd, vecs[i].wr, vecs[i].req, vecs[i].iack);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].e_oe, vecs[i].e_dout);
      next_cycle();
    end

    // ---- req[4] held high across a mid-cycle reset ----
    drive(IFA, 8'h00, 1'b1, 1'b0, 5'h10, 8'h00);
    #1;
    reset = 1'b1;
    #1;
    check_outs("rst_async", 8'h00, 1'b1, 8'he0);
    next_cycle();
    next_cycle();
    #2;
    check_outs("rst_hold", 8'h00, 1'b1, 8'he0);
    next_cycle();
    reset = 1'b0;
    #2;
    check_outs("rst_rel", 8'h00, 1'b1, 8'he0);
    next_cycle();
    #2;
    check_outs("rst_reset_edge", 8'h00, 1'b1, 8'hf0);
    // Clear IF while req stays high: no further edge, bit must stay clear.
    drive(IFA, 8'h00, 1'b0, 1'b1, 5'h10, 8'h00);
    next_cycle();
    drive(IFA, 8'h00, 1'b1, 1'b0, 5'h10, 8'h00);
    next_cycle();
    next_cycle();
    #2;
    check_outs("rst_no_reset", 8'h00, 1'b1, 8'he0);
    next_cycle();

    // ---- randomized traffic against the model ----
    reset = 1'b1;
    drive(IFA, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    next_cycle();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 500; n++) begin
      logic [15:0] a;
      logic [4:0]  q;
      logic [4:0]  flip;
      case ($urandom_range(0, 3))
        0, 1:    a = IFA;
        2:       a = IEA;
        default: a = 16'($urandom);
      endcase
      flip = 5'($urandom) & 5'($urandom);
      q    = req ^ flip;
      drive(a, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), q,
            ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00);
      #2;
      check_model($sformatf("rnd%0d", n));
      model_step();
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
